// File: rtl/obc_da_bin_acc_if.sv
// Handshake and configuration bundle for the OBC distributed-arithmetic bin engine.
// master = frame source / configuration host, slave = engine.
interface obc_da_bin_acc_if #(
    parameter int DATA_W = 16,
    parameter int NPAIR  = 4,
    parameter int COEF_W = 32,
    localparam int ACC_W = COEF_W + DATA_W + $clog2(NPAIR) + 1
);
    logic                        cfg_we;
    logic [$clog2(NPAIR):0]      cfg_addr;
    logic                        cfg_ofs_we;
    logic [COEF_W-1:0]           cfg_data;
    logic                        cfg_err;
    logic                        in_valid;
    logic                        in_ready;
    logic [2*NPAIR*DATA_W-1:0]   in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [ACC_W-1:0]            out_data;

    modport master (
        output cfg_we, cfg_addr, cfg_ofs_we, cfg_data, in_valid, in_data, out_ready,
        input  cfg_err, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_ofs_we, cfg_data, in_valid, in_data, out_ready,
        output cfg_err, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/obc_da_bin_acc.sv
// Bit-serial OBC distributed-arithmetic engine: one DFT bin component per frame,
// MSB first, programmable per-pair coefficient table plus a final offset.
module obc_da_bin_acc #(
    parameter int DATA_W = 16,
    parameter int NPAIR  = 4,
    parameter int COEF_W = 32,
    localparam int ACC_W = COEF_W + DATA_W + $clog2(NPAIR) + 1
) (
    input logic             clk,
    input logic             rst,
    obc_da_bin_acc_if.slave bus
);
    localparam int NSMP  = 2 * NPAIR;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_reg;
    logic [CNT_W-1:0]           cnt_reg;
    logic signed [ACC_W-1:0]    acc_reg;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    out_data_reg;
    logic                       in_ready_reg;
    logic                       out_valid_reg;
    logic                       cfg_err_reg;
    logic [DATA_W-1:0]          smp_reg [NSMP];
    logic signed [COEF_W-1:0]   tbl_reg [NSMP];
    logic signed [COEF_W-1:0]   ofs_reg;
    logic signed [ACC_W-1:0]    term [NPAIR];
    logic signed [ACC_W-1:0]    psum;
    logic signed [ACC_W-1:0]    ofs_ext;

    // The table is read combinationally from the registered copy, so a write
    // landing on the accept edge is already visible on the first RUN cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NPAIR; gi++) begin : g_pair
            logic                     sel;
            logic signed [COEF_W-1:0] coef;
            assign sel      = smp_reg[2*gi][DATA_W-1] ^ smp_reg[2*gi+1][DATA_W-1];
            assign coef     = sel ? tbl_reg[2*gi+1] : tbl_reg[2*gi];
            assign term[gi] = {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};
        end
    endgenerate

    always_comb begin
        psum = '0;
        for (int k = 0; k < NPAIR; k++) begin
            psum = psum + term[k];
        end
    end

    assign ofs_ext = {{(ACC_W-COEF_W){ofs_reg[COEF_W-1]}}, ofs_reg};

    // The sign bit carries negative weight, so the first step subtracts.
    always_comb begin
        if (cnt_reg == '0) begin
            acc_next = -psum;
        end else begin
            acc_next = (acc_reg <<< 1) + psum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
            ofs_reg       <= '0;
            for (int i = 0; i < NSMP; i++) begin
                smp_reg[i] <= '0;
                tbl_reg[i] <= '0;
            end
        end else begin
            cfg_err_reg <= (bus.cfg_we | bus.cfg_ofs_we) && (state_reg != IDLE);

            if (state_reg == IDLE) begin
                if (bus.cfg_we && (int'(bus.cfg_addr) < NSMP)) begin
                    tbl_reg[bus.cfg_addr] <= bus.cfg_data;
                end
                if (bus.cfg_ofs_we) begin
                    ofs_reg <= bus.cfg_data;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < NSMP; i++) begin
                            smp_reg[i] <= bus.in_data[i*DATA_W +: DATA_W];
                        end
                        acc_reg      <= '0;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSMP; i++) begin
                        smp_reg[i] <= smp_reg[i] << 1;
                    end
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                        out_data_reg  <= acc_next + ofs_ext;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.cfg_err   = cfg_err_reg;
endmodule

// File: tb/tb_obc_da_bin_acc.sv
// Bench for obc_da_bin_acc: a 4-bit single-pair instance for hand-checkable cases
// and a default instance driven with bin constants and random tables/frames.
module tb_obc_da_bin_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obc_da_bin_acc_if #(.DATA_W(4), .NPAIR(1), .COEF_W(8)) s_if ();
    obc_da_bin_acc_if d_if ();

    obc_da_bin_acc #(.DATA_W(4), .NPAIR(1), .COEF_W(8)) u_small (
        .clk(clk), .rst(rst), .bus(s_if.slave)
    );
    obc_da_bin_acc u_dflt (
        .clk(clk), .rst(rst), .bus(d_if.slave)
    );

    int     nvec  = 0;
    int     nfail = 0;
    longint s_tbl [8];
    longint s_ofs;
    longint d_tbl [8];
    longint d_ofs;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Closed-form DA sum: every bit position weighted by 2^j, sign bit negative.
    function automatic longint model(input int dw, input int np, input longint tb [8],
                                     input longint ofs, input int xs [8]);
        longint r;
        longint p;
        int     s;
        r = ofs;
        for (int j = 0; j < dw; j++) begin
            p = 0;
            for (int k = 0; k < np; k++) begin
                s = ((xs[2*k] >> j) ^ (xs[2*k+1] >> j)) & 1;
                p += tb[2*k+s];
            end
            if (j == dw - 1) r -= p <<< j;
            else             r += p <<< j;
        end
        return r;
    endfunction

    task automatic s_cfg(input int addr, input int data, input bit we, input bit ofs);
        @(negedge clk);
        s_if.cfg_we     = we;
        s_if.cfg_ofs_we = ofs;
        s_if.cfg_addr   = addr[0];
        s_if.cfg_data   = data[7:0];
        @(negedge clk);
        s_if.cfg_we     = 1'b0;
        s_if.cfg_ofs_we = 1'b0;
        if (we)  s_tbl[addr] = longint'($signed(data[7:0]));
        if (ofs) s_ofs       = longint'($signed(data[7:0]));
        check("small cfg_err idle", s_if.cfg_err, 0);
    endtask

    task automatic d_cfg(input int addr, input int data, input bit we, input bit ofs);
        @(negedge clk);
        d_if.cfg_we     = we;
        d_if.cfg_ofs_we = ofs;
        d_if.cfg_addr   = addr[2:0];
        d_if.cfg_data   = data;
        @(negedge clk);
        d_if.cfg_we     = 1'b0;
        d_if.cfg_ofs_we = 1'b0;
        if (we)  d_tbl[addr] = longint'(data);
        if (ofs) d_ofs       = longint'(data);
    endtask

    task automatic s_frame(input logic [3:0] x0, input logic [3:0] x1, input string tag,
                           input bit wr, input int wd);
        int                 xs [8];
        longint             exp;
        int                 n;
        logic signed [63:0] v;
        xs    = '{default: 0};
        xs[0] = int'(x0);
        xs[1] = int'(x1);
        @(negedge clk);
        check({tag, " in_ready"}, s_if.in_ready, 1);
        s_if.in_valid = 1'b1;
        s_if.in_data  = {x1, x0};
        if (wr) begin
            s_if.cfg_we   = 1'b1;
            s_if.cfg_addr = 1'b1;
            s_if.cfg_data = wd[7:0];
            s_tbl[1]      = longint'($signed(wd[7:0]));
        end
        @(negedge clk);
        s_if.in_valid = 1'b0;
        s_if.cfg_we   = 1'b0;
        exp = model(4, 1, s_tbl, s_ofs, xs);
        n = 0;
        while (s_if.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 4);
        v = $signed(s_if.out_data);
        check(tag, v, exp);
        $display("small %s x0=%b x1=%b out_data=%0d", tag, x0, x1, v);
        s_if.out_ready = 1'b1;
        @(negedge clk);
        s_if.out_ready = 1'b0;
        check({tag, " back to idle"}, s_if.in_ready, 1);
    endtask

    task automatic d_frame(input int xs [8], input string tag, input int hold, input bit midcfg);
        longint             exp;
        int                 n;
        logic signed [63:0] v;
        exp = model(16, 4, d_tbl, d_ofs, xs);
        @(negedge clk);
        check({tag, " in_ready"}, d_if.in_ready, 1);
        d_if.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) d_if.in_data[i*16 +: 16] = xs[i][15:0];
        @(negedge clk);
        d_if.in_valid = 1'b0;
        n = 0;
        if (midcfg) begin
            d_if.cfg_we   = 1'b1;
            d_if.cfg_addr = 3'd0;
            d_if.cfg_data = 32'h1234_5678;
            @(negedge clk);
            n++;
            d_if.cfg_we = 1'b0;
            check({tag, " cfg_err pulse"}, d_if.cfg_err, 1);
            @(negedge clk);
            n++;
            check({tag, " cfg_err clear"}, d_if.cfg_err, 0);
        end
        while (d_if.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 16);
        v = $signed(d_if.out_data);
        check(tag, v, exp);
        $display("dflt %s out_data=%0d expected=%0d", tag, v, exp);
        if (hold > 0) begin
            d_if.in_valid = 1'b1;
            d_if.in_data  = '1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({tag, " hold valid"}, d_if.out_valid, 1);
                v = $signed(d_if.out_data);
                check({tag, " hold data"}, v, exp);
                check({tag, " hold in_ready"}, d_if.in_ready, 0);
            end
            d_if.in_valid = 1'b0;
        end
        d_if.out_ready = 1'b1;
        @(negedge clk);
        d_if.out_ready = 1'b0;
        check({tag, " back to idle"}, d_if.in_ready, 1);
        check({tag, " valid low"}, d_if.out_valid, 0);
    endtask

    initial begin
        int xs [8];
        int c0, c1, c2;
        bit seen;

        s_if.cfg_we = 0; s_if.cfg_ofs_we = 0; s_if.cfg_addr = '0; s_if.cfg_data = '0;
        s_if.in_valid = 0; s_if.in_data = '0; s_if.out_ready = 0;
        d_if.cfg_we = 0; d_if.cfg_ofs_we = 0; d_if.cfg_addr = '0; d_if.cfg_data = '0;
        d_if.in_valid = 0; d_if.in_data = '0; d_if.out_ready = 0;
        s_tbl = '{default: 0}; s_ofs = 0;
        d_tbl = '{default: 0}; d_ofs = 0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst small in_ready", s_if.in_ready, 1);
        check("rst small out_valid", s_if.out_valid, 0);
        check("rst small out_data", s_if.out_data, 0);
        check("rst small cfg_err", s_if.cfg_err, 0);
        check("rst dflt in_ready", d_if.in_ready, 1);
        check("rst dflt out_valid", d_if.out_valid, 0);
        check("rst dflt out_data", d_if.out_data, 0);

        // Small instance: hand-checkable table T0=3, T1=5, OFS=10
        s_cfg(0, 3, 1, 0);
        s_cfg(1, 10, 1, 1);
        s_frame(4'b0000, 4'b1111, "both strobes", 0, 0);
        check("both strobes ofs", s_ofs, 10);
        s_cfg(1, 5, 1, 0);
        s_frame(4'b0101, 4'b0011, "mixed sel", 0, 0);
        check("mixed sel literal", $signed(s_if.out_data), 19);
        s_frame(4'b0000, 4'b1111, "all sel1", 0, 0);
        check("all sel1 literal", $signed(s_if.out_data), 5);
        s_frame(4'b1010, 4'b1010, "all sel0", 0, 0);
        check("all sel0 literal", $signed(s_if.out_data), 7);
        s_frame(4'b0000, 4'b1111, "write at accept", 1, 7);
        check("write at accept literal", $signed(s_if.out_data), 3);

        // Default instance: Q10.21 bin constants
        c0 = 1482910;
        c1 = 802545;
        c2 = 1937516;
        d_cfg(0, c0, 1, 0);  d_cfg(1, -c0, 1, 0);
        d_cfg(2, c1, 1, 0);  d_cfg(3, -c1, 1, 0);
        d_cfg(4, c2, 1, 0);  d_cfg(5, -c2, 1, 0);
        d_cfg(6, -c0, 1, 0); d_cfg(7, c0, 1, 0);
        d_cfg(0, c1, 0, 1);
        xs = '{default: 1};
        d_frame(xs, "bin all ones", 0, 0);
        for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 65535));
        d_frame(xs, "backpressure", 7, 0);
        for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 65535));
        d_frame(xs, "cfg in run", 0, 1);
        for (int r = 0; r < 5; r++) begin
            for (int a = 0; a < 8; a++) d_cfg(a, int'($urandom), 1, 0);
            d_cfg(0, int'($urandom), 0, 1);
            for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 65535));
            d_frame(xs, $sformatf("random %0d", r), 0, 0);
        end

        // Reset in the middle of a small-instance frame (cnt=2)
        @(negedge clk);
        s_if.in_valid = 1'b1;
        s_if.in_data  = 8'h35;
        @(negedge clk);
        s_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst in_ready", s_if.in_ready, 1);
        check("mid rst out_valid", s_if.out_valid, 0);
        check("mid rst out_data", s_if.out_data, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (s_if.out_valid !== 1'b0) seen = 1'b1;
        end
        check("mid rst no out_valid", seen, 0);
        s_tbl = '{default: 0}; s_ofs = 0;
        d_tbl = '{default: 0}; d_ofs = 0;
        s_frame(4'b0101, 4'b0011, "post rst small", 0, 0);
        check("post rst small literal", $signed(s_if.out_data), 0);
        for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 65535));
        d_frame(xs, "post rst dflt", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
